// File: rtl/order_dispatch_ctrl.sv
// Gates trade triggers (rate limit, in-flight cap, enable, fault) and offers accepted orders to the router.
// Latency: trigger at cycle N -> ord_valid at N+1; ord_valid holds until ord_ready; triggers seen while busy are dropped.
module order_dispatch_ctrl #(
    parameter int PRICE_W       = 32,
    parameter int MAX_INFLIGHT  = 4,
    parameter int TOKEN_MAX     = 8,
    parameter int REFILL_PERIOD = 1000,
    parameter int ACK_TIMEOUT   = 5000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig_valid,
    input  logic [PRICE_W-1:0] trig_price,
    input  logic               trig_side,
    input  logic               enable,
    input  logic               clear_fault,
    output logic               ord_valid,
    input  logic               ord_ready,
    output logic [PRICE_W-1:0] ord_price,
    output logic               ord_side,
    input  logic               ack_valid,
    output logic [3:0]         inflight_cnt,
    output logic [7:0]         tokens,
    output logic [15:0]        drop_cnt,
    output logic               fault
);

    localparam int RF_W = $clog2(REFILL_PERIOD);
    localparam int WD_W = $clog2(ACK_TIMEOUT);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e             state_q, state_d;
    logic               ord_valid_q, ord_valid_d;
    logic [PRICE_W-1:0] ord_price_q, ord_price_d;
    logic               ord_side_q, ord_side_d;
    logic [3:0]         inflight_q, inflight_d;
    logic [7:0]         tokens_q, tokens_d;
    logic [15:0]        drop_q, drop_d;
    logic               fault_q, fault_d;
    logic [RF_W-1:0]    refill_q, refill_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    logic accept, handshake, refill_tc;

    always_comb begin
        state_d     = state_q;
        ord_valid_d = ord_valid_q;
        ord_price_d = ord_price_q;
        ord_side_d  = ord_side_q;
        inflight_d  = inflight_q;
        tokens_d    = tokens_q;
        drop_d      = drop_q;
        fault_d     = fault_q;
        wdog_d      = wdog_q;

        accept    = (state_q == IDLE) && trig_valid && enable && !fault_q &&
                    (tokens_q != 8'd0) && (inflight_q < 4'(MAX_INFLIGHT));
        handshake = (state_q == ISSUE) && ord_valid_q && ord_ready;
        refill_tc = (refill_q == RF_W'(REFILL_PERIOD - 1));
        refill_d  = refill_tc ? '0 : refill_q + RF_W'(1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = ISSUE;
                    ord_valid_d = 1'b1;
                    ord_price_d = trig_price;
                    ord_side_d  = trig_side;
                end
            end
            ISSUE: begin
                // Once offered, the order stays up regardless of enable/fault.
                if (handshake) begin
                    state_d     = IDLE;
                    ord_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (trig_valid && !accept && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;

        if (accept && !refill_tc)
            tokens_d = tokens_q - 8'd1;
        else if (!accept && refill_tc && (tokens_q < 8'(TOKEN_MAX)))
            tokens_d = tokens_q + 8'd1;

        // A simultaneous issue and ack cancel out; ack with nothing outstanding is ignored.
        if (handshake && !ack_valid && (inflight_q != 4'hF))
            inflight_d = inflight_q + 4'd1;
        else if (ack_valid && !handshake && (inflight_q != 4'd0))
            inflight_d = inflight_q - 4'd1;

        if (ack_valid || (inflight_q == 4'd0)) begin
            wdog_d = '0;
        end else if (!fault_q) begin
            if (wdog_q == WD_W'(ACK_TIMEOUT - 1))
                fault_d = 1'b1;
            else
                wdog_d = wdog_q + WD_W'(1);
        end

        if (clear_fault) begin
            fault_d    = 1'b0;
            inflight_d = 4'd0;
            wdog_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ord_valid_q <= 1'b0;
            ord_price_q <= '0;
            ord_side_q  <= 1'b0;
            inflight_q  <= 4'd0;
            tokens_q    <= 8'(TOKEN_MAX);
            drop_q      <= 16'd0;
            fault_q     <= 1'b0;
            refill_q    <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            ord_valid_q <= ord_valid_d;
            ord_price_q <= ord_price_d;
            ord_side_q  <= ord_side_d;
            inflight_q  <= inflight_d;
            tokens_q    <= tokens_d;
            drop_q      <= drop_d;
            fault_q     <= fault_d;
            refill_q    <= refill_d;
            wdog_q      <= wdog_d;
        end
    end

    assign ord_valid    = ord_valid_q;
    assign ord_price    = ord_price_q;
    assign ord_side     = ord_side_q;
    assign inflight_cnt = inflight_q;
    assign tokens       = tokens_q;
    assign drop_cnt     = drop_q;
    assign fault        = fault_q;

endmodule

// File: doc/order_dispatch_ctrl.md
Name: order_dispatch_ctrl

Overview:
- Sequences trade triggers from the tick-to-trade core (the single-cycle send_order pulse, with price and side) into the IOC/FOK order router.
- Gates each trigger against a token-bucket rate limit, an outstanding-order cap, an operator enable and a latched ack-timeout fault.
- Presents accepted orders on a valid/ready handshake and tracks in-flight orders until the exchange acknowledges them.

Parameters:
- PRICE_W, 32, price field width.
- MAX_INFLIGHT, 4, maximum unacknowledged orders (1..15).
- TOKEN_MAX, 8, bucket depth and reset fill level (1..255).
- REFILL_PERIOD, 1000, cycles per token added (>=2).
- ACK_TIMEOUT, 5000, cycles without an ack while inflight>0 before fault (>=2).

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- trig_valid  in  1  one-cycle trade trigger.
- trig_price  in  PRICE_W  order price, valid with trig_valid.
- trig_side  in  1  0=BUY, 1=SELL.
- enable  in  1  operator kill switch; 0 rejects new triggers.
- clear_fault  in  1  one-cycle pulse; clears fault and in-flight count.
- ord_valid  out  1  order offered to the router.
- ord_ready  in  1  router accepts the order.
- ord_price  out  PRICE_W  latched price.
- ord_side  out  1  latched side.
- ack_valid  in  1  one-cycle pulse: one outstanding order resolved (fill or reject).
- inflight_cnt  out  4  outstanding order count.
- tokens  out  8  current token level.
- drop_cnt  out  16  rejected-trigger count, saturating at 0xFFFF.
- fault  out  1  ack timeout latched.

Behaviour:
- Reset (rst_n=0 at an edge): ord_valid=0, ord_price=0, ord_side=0, inflight_cnt=0, tokens=TOKEN_MAX, drop_cnt=0, fault=0, refill and watchdog counters=0, FSM=IDLE.
  - Reset mid-handshake drops the pending order without waiting for ord_ready.
- FSM states: IDLE and ISSUE.
- IDLE, trig_valid=1:
  - Accept if enable=1, fault=0, tokens>0 and inflight_cnt<MAX_INFLIGHT.
    - Latch price and side, decrement tokens, go to ISSUE.
    - ord_valid rises the next cycle (trigger at cycle N -> ord_valid at N+1).
  - Otherwise drop: drop_cnt+1 (saturating). State unchanged.
- ISSUE:
  - ord_valid=1; ord_price and ord_side held stable until ord_valid&&ord_ready.
  - No retraction: enable falling or fault rising during ISSUE does not drop ord_valid.
  - On handshake: inflight_cnt+1, ord_valid=0 the next cycle, go to IDLE.
  - Any trig_valid seen in ISSUE, including the handshake cycle, is dropped and counted. There is no queue.
- Minimum spacing between orders: 2 cycles when ord_ready is tied high.
- Token refill:
  - Free-running counter 0..REFILL_PERIOD-1.
  - At terminal count, tokens+1, saturating at TOKEN_MAX.
  - Refill and consume in the same cycle: net 0.
- In-flight tracking:
  - ack_valid decrements inflight_cnt.
  - ack_valid when inflight_cnt=0 is ignored (no underflow).
  - Handshake and ack in the same cycle: net 0.
- Watchdog:
  - Counts while inflight_cnt>0 and fault=0.
  - Clears on ack_valid and whenever inflight_cnt=0.
  - Reaching ACK_TIMEOUT-1 sets fault on the next edge. Fault is sticky; the watchdog holds.
- clear_fault:
  - Forces fault=0, inflight_cnt=0 and watchdog=0.
  - Overrides a simultaneous handshake increment or ack in the same cycle.
  - A trigger in the same cycle is evaluated against the pre-clear fault value (dropped if fault was 1).
- drop_cnt, tokens and inflight_cnt never wrap.

Test Plan:
- Trigger at cycle 10 (price 0x1234, side 1) with ord_ready=1 -> ord_valid high at cycle 11 with 0x1234/1; inflight_cnt=1; tokens=7.
- ord_ready held low 20 cycles, 3 triggers during ISSUE, enable pulsed low -> ord_valid and payload stable throughout; drop_cnt=3; handshake completes when ord_ready rises.
- 9 triggers spaced 3 cycles, MAX_INFLIGHT=15, acks returned -> 8 orders issued, 9th dropped (tokens=0); after 1000 cycles tokens=1 and the next trigger is accepted.
- 4 accepted orders, no acks, further trigger -> dropped (cap); one ack -> next trigger is accepted.
- One order, no ack for 5000 cycles -> fault=1 at cycle ACK_TIMEOUT after issue; triggers dropped; clear_fault -> fault=0, inflight_cnt=0, triggers accepted.
- ack_valid with inflight_cnt=0, and handshake+ack in the same cycle -> inflight_cnt unchanged in both cases; assert rst_n=0 during ISSUE -> all outputs at reset values the next cycle.
